// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - opcodes, element/group codes and sequencer states shared by the vALU path
package valu_pkg;

  localparam logic [3:0] VALU_ADD  = 4'd0;
  localparam logic [3:0] VALU_ADDS = 4'd1;
  localparam logic [3:0] VALU_SUB  = 4'd2;
  localparam logic [3:0] VALU_SUBS = 4'd3;
  localparam logic [3:0] VALU_MUL  = 4'd4;
  localparam logic [3:0] VALU_MULS = 4'd5;
  localparam logic [3:0] VALU_AND  = 4'd6;
  localparam logic [3:0] VALU_OR   = 4'd7;
  localparam logic [3:0] VALU_XOR  = 4'd8;
  localparam logic [3:0] VALU_OP_MAX = VALU_XOR;

  localparam logic [2:0] SEW_8  = 3'd0;
  localparam logic [2:0] SEW_16 = 3'd1;
  localparam logic [2:0] SEW_32 = 3'd2;
  localparam logic [2:0] SEW_64 = 3'd3;

  localparam logic [1:0] LMUL_1 = 2'd0;
  localparam logic [1:0] LMUL_2 = 2'd1;
  localparam logic [1:0] LMUL_4 = 2'd2;
  localparam logic [1:0] LMUL_8 = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_e;

endpackage

// File: rtl/valu_tail_mask.sv
// rtl/valu_tail_mask.sv - byte enables for group register k: bytes whose element index is below vl
module valu_tail_mask (
  input  logic [2:0] k_i,
  input  logic [1:0] sew_i,
  input  logic [6:0] vl_i,
  output logic [7:0] be_o
);

  logic [9:0] lim;

  always_comb begin
    lim  = {3'b000, vl_i} << sew_i;
    be_o = '0;
    for (int b = 0; b < 8; b++) begin
      be_o[b] = ({4'b0000, k_i, 3'(b)} < lim);
    end
  end

endmodule

// File: rtl/valu_seq.sv
// rtl/valu_seq.sv - walks one vector command's register group through VRF read, vALU and tail-masked write
module valu_seq
  import valu_pkg::*;
#(
  parameter int NREG = 32,
  parameter int VLEN = 64,
  localparam int AW = $clog2(NREG),
  localparam int NB = VLEN / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [3:0]      cmd_op,
  input  logic [2:0]      cmd_sew,
  input  logic [1:0]      cmd_lmul,
  input  logic [6:0]      cmd_vl,
  input  logic [AW-1:0]   cmd_vs1,
  input  logic [AW-1:0]   cmd_vs2,
  input  logic [AW-1:0]   cmd_vd,
  input  logic [VLEN-1:0] cmd_scalar,
  output logic            vrf_rd_en,
  output logic [AW-1:0]   vrf_rd_addr1,
  output logic [AW-1:0]   vrf_rd_addr2,
  input  logic [VLEN-1:0] vrf_rd_data1,
  input  logic [VLEN-1:0] vrf_rd_data2,
  output logic [VLEN-1:0] valu_in1,
  output logic [VLEN-1:0] valu_in2,
  output logic [VLEN-1:0] valu_scalar,
  output logic [3:0]      valu_op,
  output logic [2:0]      valu_sew,
  input  logic [VLEN-1:0] valu_result,
  output logic            vrf_wr_en,
  output logic [AW-1:0]   vrf_wr_addr,
  output logic [NB-1:0]   vrf_wr_be,
  output logic [VLEN-1:0] vrf_wr_data,
  output logic            done,
  output logic            err,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic            drain_q, drain_d;

  logic [3:0]      op_q;
  logic [2:0]      sew_q;
  logic [1:0]      lmul_q;
  logic [6:0]      vl_q;
  logic [AW-1:0]   vs1_q, vs2_q, vd_q;
  logic [VLEN-1:0] scalar_q;
  logic            err_q;

  logic            rd_vld_q;
  logic [2:0]      k1_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [NB-1:0]   wr_be_q;
  logic [VLEN-1:0] wr_data_q;

  logic            accept;
  logic [3:0]      grp;
  logic [AW-1:0]   align;
  logic            bad;
  logic [7:0]      vlmax;
  logic [6:0]      vl_eff;
  logic [2:0]      last_k;
  logic [NB-1:0]   tail_be;
  logic            idle;

  // Alignment: a group base must have its low lmul bits clear.
  always_comb begin
    accept = cmd_valid && (state_q == IDLE);
    grp    = 4'd1 << cmd_lmul;
    align  = AW'(grp - 4'd1);
    bad    = (cmd_op > VALU_OP_MAX) || (cmd_sew > SEW_64) ||
             (|((cmd_vs1 | cmd_vs2 | cmd_vd) & align));
    vlmax  = (8'(NB) >> cmd_sew[1:0]) << cmd_lmul;
    vl_eff = ({1'b0, cmd_vl} > vlmax) ? vlmax[6:0] : cmd_vl;
    last_k = 3'((4'd1 << lmul_q) - 4'd1);
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    drain_d   = drain_q;
    cmd_ready = 1'b0;
    vrf_rd_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (accept) begin
          k_d     = 3'd0;
          state_d = (bad || (vl_eff == 7'd0)) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        vrf_rd_en = 1'b1;
        if (k_q == last_k) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sew_q    <= '0;
      lmul_q   <= '0;
      vl_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      scalar_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q     <= cmd_op;
      sew_q    <= cmd_sew;
      lmul_q   <= cmd_lmul;
      vl_q     <= vl_eff;
      vs1_q    <= cmd_vs1;
      vs2_q    <= cmd_vs2;
      vd_q     <= cmd_vd;
      scalar_q <= cmd_scalar;
      err_q    <= bad;
    end
  end

  assign busy         = ~cmd_ready;
  assign idle         = (state_q == IDLE);
  assign vrf_rd_addr1 = vrf_rd_en ? vs1_q + AW'(k_q) : '0;
  assign vrf_rd_addr2 = vrf_rd_en ? vs2_q + AW'(k_q) : '0;
  assign valu_in1     = idle ? '0 : vrf_rd_data1;
  assign valu_in2     = idle ? '0 : vrf_rd_data2;
  assign valu_scalar  = idle ? '0 : scalar_q;
  assign valu_op      = idle ? '0 : op_q;
  assign valu_sew     = idle ? '0 : sew_q;

  valu_tail_mask u_tail_mask (
    .k_i   (k1_q),
    .sew_i (sew_q[1:0]),
    .vl_i  (vl_q),
    .be_o  (tail_be)
  );

  // Stage 1 tracks which group register's data returns this cycle; stage 2 is the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      k1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_be_q   <= '0;
      wr_data_q <= '0;
    end else begin
      rd_vld_q  <= vrf_rd_en;
      k1_q      <= k_q;
      wr_en_q   <= rd_vld_q;
      wr_addr_q <= rd_vld_q ? vd_q + AW'(k1_q) : '0;
      wr_be_q   <= rd_vld_q ? tail_be : '0;
      wr_data_q <= rd_vld_q ? valu_result : '0;
    end
  end

  assign vrf_wr_en   = wr_en_q;
  assign vrf_wr_addr = wr_addr_q;
  assign vrf_wr_be   = wr_be_q;
  assign vrf_wr_data = wr_data_q;

endmodule

// File: tb/tb_valu_seq.sv
// tb/tb_valu_seq.sv - directed bench for valu_seq with a VRF/vALU environment and a per-cycle reference model
module tb_valu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_sew;
  logic [1:0]  cmd_lmul;
  logic [6:0]  cmd_vl;
  logic [4:0]  cmd_vs1, cmd_vs2, cmd_vd;
  logic [63:0] cmd_scalar;
  logic        vrf_rd_en;
  logic [4:0]  vrf_rd_addr1, vrf_rd_addr2;
  logic [63:0] vrf_rd_data1, vrf_rd_data2;
  logic [63:0] valu_in1, valu_in2, valu_scalar, valu_result;
  logic [3:0]  valu_op;
  logic [2:0]  valu_sew;
  logic        vrf_wr_en;
  logic [4:0]  vrf_wr_addr;
  logic [7:0]  vrf_wr_be;
  logic [63:0] vrf_wr_data;
  logic        done, err, busy;

  always #5 clk = ~clk;

  valu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sew(cmd_sew),
    .cmd_lmul(cmd_lmul), .cmd_vl(cmd_vl), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2),
    .cmd_vd(cmd_vd), .cmd_scalar(cmd_scalar),
    .vrf_rd_en(vrf_rd_en), .vrf_rd_addr1(vrf_rd_addr1), .vrf_rd_addr2(vrf_rd_addr2),
    .vrf_rd_data1(vrf_rd_data1), .vrf_rd_data2(vrf_rd_data2),
    .valu_in1(valu_in1), .valu_in2(valu_in2), .valu_scalar(valu_scalar),
    .valu_op(valu_op), .valu_sew(valu_sew), .valu_result(valu_result),
    .vrf_wr_en(vrf_wr_en), .vrf_wr_addr(vrf_wr_addr), .vrf_wr_be(vrf_wr_be),
    .vrf_wr_data(vrf_wr_data), .done(done), .err(err), .busy(busy)
  );

  // Elementwise vALU behaviour: vector ops combine vs2 with vs1, scalar ops combine vs2 with the scalar.
  function automatic logic [63:0] valu_fn(input logic [3:0] op, input logic [2:0] sew,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] s);
    int w;
    logic [63:0] m, x, y, z, r, res;
    res = '0;
    if (sew > 3'd3) return res;
    w = 8 << sew;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    for (int e = 0; e < 64 / w; e++) begin
      x = (a >> (e * w)) & m;
      y = (b >> (e * w)) & m;
      z = s & m;
      case (op)
        4'd0:    r = y + x;
        4'd1:    r = y + z;
        4'd2:    r = y - x;
        4'd3:    r = y - z;
        4'd4:    r = y * x;
        4'd5:    r = y * z;
        4'd6:    r = y & x;
        4'd7:    r = y | x;
        4'd8:    r = y ^ x;
        default: r = '0;
      endcase
      res = res | ((r & m) << (e * w));
    end
    return res;
  endfunction

  assign valu_result = valu_fn(valu_op, valu_sew, valu_in1, valu_in2, valu_scalar);

  function automatic logic [7:0] model_be(input int k, input int sew, input int vl);
    logic [7:0] be;
    for (int b = 0; b < 8; b++) be[b] = (((8 * k + b) / (1 << sew)) < vl);
    return be;
  endfunction

  typedef struct packed {
    bit          busy, rd, wr, dn, er;
    logic [4:0]  ra1, ra2, wa;
    logic [7:0]  be;
    logic [63:0] wd;
  } exp_t;

  typedef struct packed {
    int          rel;
    logic [4:0]  a;
    logic [7:0]  be;
    logic [63:0] d;
  } obs_t;

  exp_t        ex[int];
  obs_t        obs[$];
  logic [63:0] env_mem [32];
  logic [63:0] mm      [32];
  int          cyc = 0;
  int          last_acc = 0;
  int          n_vec = 0, n_err = 0;
  int          n_rd, n_done, done_rel;
  logic        done_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic set_reg(input int r, input logic [63:0] v);
    env_mem[r] = v;
    mm[r]      = v;
  endtask

  task automatic predict(input int c0, input int op, input int sew, input int lmul, input int vl,
                         input int vs1, input int vs2, input int vd, input logic [63:0] sc);
    int   L, vle;
    bit   bad;
    exp_t e;
    L   = 1 << lmul;
    bad = (op > 8) || (sew > 3) || (vs1 % L != 0) || (vs2 % L != 0) || (vd % L != 0);
    vle = 0;
    if (!bad) vle = (vl < L * (8 >> sew)) ? vl : L * (8 >> sew);
    if (bad || vle == 0) begin
      e = '0; e.busy = 1'b1; e.dn = 1'b1; e.er = bad;
      ex[c0 + 1] = e;
    end else begin
      for (int c = c0 + 1; c <= c0 + L + 2; c++) begin
        e = '0; e.busy = 1'b1; ex[c] = e;
      end
      for (int k = 0; k < L; k++) begin
        e = ex[c0 + 1 + k]; e.rd = 1'b1; e.ra1 = 5'(vs1 + k); e.ra2 = 5'(vs2 + k);
        ex[c0 + 1 + k] = e;
        e = ex[c0 + 3 + k]; e.wr = 1'b1; e.wa = 5'(vd + k); e.be = model_be(k, sew, vle);
        e.wd = valu_fn(4'(op), 3'(sew), mm[vs1 + k], mm[vs2 + k], sc);
        ex[c0 + 3 + k] = e;
      end
      e = ex[c0 + L + 2]; e.dn = 1'b1; ex[c0 + L + 2] = e;
    end
  endtask

  task automatic purge(input int from);
    int ks[$];
    foreach (ex[i]) if (i >= from) ks.push_back(i);
    foreach (ks[j]) ex.delete(ks[j]);
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] sew, input logic [1:0] lmul,
                       input logic [6:0] vl, input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [4:0] vd, input logic [63:0] sc);
    int guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("ready_before_issue", 64'(cmd_ready), 64'd1);
    obs.delete();
    n_rd = 0; n_done = 0; done_rel = -1; done_err = 1'bx;
    cmd_op = op; cmd_sew = sew; cmd_lmul = lmul; cmd_vl = vl;
    cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vd = vd; cmd_scalar = sc;
    cmd_valid = 1'b1;
    last_acc = cyc;
    predict(cyc, int'(op), int'(sew), int'(lmul), int'(vl), int'(vs1), int'(vs2), int'(vd), sc);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input int i, input int rel, input logic [4:0] a,
                        input logic [7:0] be, input logic [63:0] d, input bit chk_data);
    if (obs.size() > i) begin
      chk({tag, "_cycle"}, 64'(obs[i].rel), 64'(rel));
      chk({tag, "_addr"}, 64'(obs[i].a), 64'(a));
      chk({tag, "_be"}, 64'(obs[i].be), 64'(be));
      if (chk_data) chk({tag, "_data"}, obs[i].d, d);
    end else begin
      chk({tag, "_present"}, 64'(obs.size()), 64'(i + 1));
    end
  endtask

  task automatic chk_done(input string tag, input int rel, input logic e);
    chk({tag, "_ndone"}, 64'(n_done), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_rel), 64'(rel));
    chk({tag, "_err"}, 64'(done_err), 64'(e));
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // VRF: one-cycle read latency, byte-enabled writes.
  initial begin : vrf_env
    logic        pend;
    logic [63:0] p1, p2;
    vrf_rd_data1 = '0;
    vrf_rd_data2 = '0;
    forever begin
      @(negedge clk);
      pend = vrf_rd_en;
      p1   = env_mem[vrf_rd_addr1];
      p2   = env_mem[vrf_rd_addr2];
      if (vrf_wr_en) begin
        for (int b = 0; b < 8; b++)
          if (vrf_wr_be[b]) env_mem[vrf_wr_addr][8 * b +: 8] = vrf_wr_data[8 * b +: 8];
      end
      @(posedge clk); #1;
      vrf_rd_data1 = pend ? p1 : '0;
      vrf_rd_data2 = pend ? p2 : '0;
    end
  end

  initial begin : compare
    exp_t e;
    forever begin
      @(negedge clk);
      e = ex.exists(cyc) ? ex[cyc] : '0;
      chk("busy", 64'(busy), 64'(e.busy));
      chk("cmd_ready", 64'(cmd_ready), 64'(!e.busy));
      chk("rd_en", 64'(vrf_rd_en), 64'(e.rd));
      if (e.rd) begin
        chk("rd_addr1", 64'(vrf_rd_addr1), 64'(e.ra1));
        chk("rd_addr2", 64'(vrf_rd_addr2), 64'(e.ra2));
      end
      chk("wr_en", 64'(vrf_wr_en), 64'(e.wr));
      if (e.wr) begin
        chk("wr_addr", 64'(vrf_wr_addr), 64'(e.wa));
        chk("wr_be", 64'(vrf_wr_be), 64'(e.be));
        chk("wr_data", vrf_wr_data, e.wd);
        for (int b = 0; b < 8; b++)
          if (e.be[b]) mm[e.wa][8 * b +: 8] = e.wd[8 * b +: 8];
      end
      chk("done", 64'(done), 64'(e.dn));
      if (e.dn) chk("err", 64'(err), 64'(e.er));
      if (vrf_rd_en) n_rd++;
      if (vrf_wr_en) obs.push_back('{rel: cyc - last_acc, a: vrf_wr_addr, be: vrf_wr_be, d: vrf_wr_data});
      if (done) begin
        n_done++;
        done_rel = cyc - last_acc;
        done_err = err;
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_sew = '0; cmd_lmul = '0; cmd_vl = '0;
    cmd_vs1 = '0; cmd_vs2 = '0; cmd_vd = '0; cmd_scalar = '0;
    for (int r = 0; r < 32; r++) set_reg(r, {32'(r * 32'h01010101), 32'(32'h9e3779b9 * (r + 1))});
    set_reg(2, 64'h0807060504030201);
    set_reg(3, 64'h1122334455667788);
    set_reg(4, 64'h0101010101010101);
    set_reg(5, 64'h00ff00ff00ff00ff);
    set_reg(10, 64'd3);

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_wr_en", 64'(vrf_wr_en), 64'd0);
    chk("rst_wr_data", vrf_wr_data, 64'd0);
    chk("rst_valu_in1", valu_in1, 64'd0);
    chk("rst_valu_op", 64'(valu_op), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(4'd0, 3'd0, 2'd0, 7'd8, 5'd2, 5'd4, 5'd6, 64'd0);
    settle();
    chk("add_nwr", 64'(obs.size()), 64'd1);
    chk_wr("add_w0", 0, 3, 5'd6, 8'hff, 64'h0908070605040302, 1'b1);
    chk_done("add", 3, 1'b0);

    issue(4'd0, 3'd1, 2'd1, 7'd5, 5'd2, 5'd4, 5'd6, 64'd0);
    settle();
    chk("tail_nwr", 64'(obs.size()), 64'd2);
    chk_wr("tail_w0", 0, 3, 5'd6, 8'hff, 64'd0, 1'b0);
    chk_wr("tail_w1", 1, 4, 5'd7, 8'h03, 64'd0, 1'b0);
    chk_done("tail", 4, 1'b0);

    issue(4'd8, 3'd2, 2'd0, 7'd5, 5'd2, 5'd4, 5'd8, 64'd0);
    settle();
    chk_wr("clamp5", 0, 3, 5'd8, 8'hff, 64'd0, 1'b0);
    issue(4'd8, 3'd2, 2'd0, 7'd1, 5'd2, 5'd4, 5'd8, 64'd0);
    settle();
    chk_wr("clamp1", 0, 3, 5'd8, 8'h0f, 64'd0, 1'b0);

    issue(4'd5, 3'd3, 2'd0, 7'd1, 5'd0, 5'd10, 5'd12, 64'hfffffffffffffffe);
    settle();
    chk_wr("muls", 0, 3, 5'd12, 8'hff, 64'hfffffffffffffffa, 1'b1);

    issue(4'd0, 3'd0, 2'd2, 7'd8, 5'd0, 5'd4, 5'd6, 64'd0);
    settle();
    chk_done("rej_align", 1, 1'b1);
    chk("rej_align_nrd", 64'(n_rd), 64'd0);
    chk("rej_align_nwr", 64'(obs.size()), 64'd0);

    issue(4'd9, 3'd0, 2'd0, 7'd8, 5'd2, 5'd4, 5'd6, 64'd0);
    settle();
    chk_done("rej_op", 1, 1'b1);
    chk("rej_op_nrd", 64'(n_rd), 64'd0);
    chk("rej_op_nwr", 64'(obs.size()), 64'd0);

    issue(4'd0, 3'd0, 2'd0, 7'd0, 5'd2, 5'd4, 5'd6, 64'd0);
    settle();
    chk_done("vl0", 1, 1'b0);
    chk("vl0_nwr", 64'(obs.size()), 64'd0);

    // Stray commands while busy must leave no trace.
    issue(4'd2, 3'd1, 2'd2, 7'd13, 5'd16, 5'd20, 5'd12, 64'd0);
    cmd_op = 4'd0; cmd_vs1 = 5'd0; cmd_vs2 = 5'd0; cmd_vd = 5'd0; cmd_lmul = 2'd0; cmd_vl = 7'd8;
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    settle();
    chk("busyign_nwr", 64'(obs.size()), 64'd4);
    chk_wr("busyign_w3", 3, 6, 5'd15, 8'h03, 64'd0, 1'b0);
    chk_done("busyign", 6, 1'b0);

    issue(4'd0, 3'd0, 2'd3, 7'd64, 5'd16, 5'd0, 5'd24, 64'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    purge(cyc);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
    settle();
    chk("rst_mid_nwr", 64'(obs.size()), 64'd2);
    chk("rst_mid_ndone", 64'(n_done), 64'd0);

    issue(4'd0, 3'd0, 2'd0, 7'd8, 5'd2, 5'd4, 5'd30, 64'd0);
    settle();
    chk("post_rst_nwr", 64'(obs.size()), 64'd1);
    chk_done("post_rst", 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
